// File: rtl/riscv_sim_ctrl.sv
// Simulation run controller for a RISC-V core: holds core reset, runs it, and
// reports how the run ended (tohost mailbox, stuck PC, or cycle timeout).
module riscv_sim_ctrl #(
   parameter int unsigned        RegBits     = 32,
   parameter int unsigned        CntBits     = 32,
   parameter int unsigned        ResetCycles = 4,
   parameter int unsigned        MaxCycles   = 1000,
   parameter int unsigned        StallCycles = 8,
   parameter logic [RegBits-1:0] ToHostAddr  = 'h0000_1000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [RegBits-1:0] pc_i,
   input  logic               memory_write_i,
   input  logic [RegBits-1:0] alu_result_i,
   input  logic [RegBits-1:0] write_data_i,
   output logic               core_rst_o,
   output logic               running_o,
   output logic               done_o,
   output logic               pass_o,
   output logic               fail_o,
   output logic               timeout_o,
   output logic               stall_o,
   output logic [RegBits-1:0] exit_code_o,
   output logic [CntBits-1:0] cycle_count_o
);

   typedef enum logic [1:0] {StIdle, StHold, StRun, StDone} state_e;

   localparam logic [7:0]         HoldLast  = 8'(ResetCycles - 1);
   localparam logic [31:0]        StallLast = 32'(StallCycles - 1);
   localparam logic [CntBits-1:0] TimeoutAt = CntBits'(MaxCycles - 1);

   state_e             state_q;
   logic [7:0]         hold_cnt_q;
   logic [31:0]        stall_cnt_q;
   logic [RegBits-1:0] prev_pc_q;
   logic               ref_valid_q;
   logic               core_rst_q;
   logic               pass_q;
   logic               fail_q;
   logic               timeout_q;
   logic               stall_q;
   logic [RegBits-1:0] exit_code_q;
   logic [CntBits-1:0] cycle_cnt_q;

   logic mbox_hit;
   logic pc_same;
   logic stall_hit;
   logic timeout_hit;

   always_comb begin
      mbox_hit    = memory_write_i && (alu_result_i == ToHostAddr);
      // ref_valid_q is low in the first RUN cycle so the reference PC is only captured
      pc_same     = ref_valid_q && (pc_i == prev_pc_q);
      stall_hit   = pc_same && (stall_cnt_q == StallLast);
      timeout_hit = (cycle_cnt_q == TimeoutAt);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= StIdle;
         hold_cnt_q  <= '0;
         stall_cnt_q <= '0;
         prev_pc_q   <= '0;
         ref_valid_q <= 1'b0;
         core_rst_q  <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
         stall_q     <= 1'b0;
         exit_code_q <= '0;
         cycle_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start_i) begin
                  state_q     <= StHold;
                  hold_cnt_q  <= '0;
                  cycle_cnt_q <= '0;
                  core_rst_q  <= 1'b0;
                  pass_q      <= 1'b0;
                  fail_q      <= 1'b0;
                  timeout_q   <= 1'b0;
                  stall_q     <= 1'b0;
                  exit_code_q <= '0;
               end
            end
            StHold: begin
               if (hold_cnt_q == HoldLast) begin
                  state_q     <= StRun;
                  core_rst_q  <= 1'b1;
                  ref_valid_q <= 1'b0;
                  stall_cnt_q <= '0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 8'd1;
               end
            end
            StRun: begin
               if (!(&cycle_cnt_q)) cycle_cnt_q <= cycle_cnt_q + 1'b1;
               prev_pc_q   <= pc_i;
               ref_valid_q <= 1'b1;
               stall_cnt_q <= pc_same ? stall_cnt_q + 32'd1 : 32'd0;
               // Exit priority: mailbox, then stuck PC, then timeout
               if (mbox_hit) begin
                  state_q     <= StDone;
                  core_rst_q  <= 1'b0;
                  exit_code_q <= write_data_i >> 1;
                  if (write_data_i == RegBits'(1)) pass_q <= 1'b1;
                  else                             fail_q <= 1'b1;
               end else if (stall_hit) begin
                  state_q    <= StDone;
                  core_rst_q <= 1'b0;
                  stall_q    <= 1'b1;
               end else if (timeout_hit) begin
                  state_q    <= StDone;
                  core_rst_q <= 1'b0;
                  timeout_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign core_rst_o    = core_rst_q;
   assign running_o     = (state_q == StRun);
   assign done_o        = (state_q == StDone);
   assign pass_o        = pass_q;
   assign fail_o        = fail_q;
   assign timeout_o     = timeout_q;
   assign stall_o       = stall_q;
   assign exit_code_o   = exit_code_q;
   assign cycle_count_o = cycle_cnt_q;

endmodule

// File: tb/tb_riscv_sim_ctrl.sv
// Bench for riscv_sim_ctrl: each run is described by a schedule, a timeline model derives
// the expected outputs for every cycle, and one process compares them at the falling edge.
module tb_riscv_sim_ctrl;

   localparam int          HoldLen  = 4;
   localparam int          MaxCyc   = 1000;
   localparam int          StallLen = 8;
   localparam logic [31:0] ToHost   = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] pc_i = '0;
   logic        memory_write_i = 1'b0;
   logic [31:0] alu_result_i = '0;
   logic [31:0] write_data_i = '0;
   logic        core_rst_o, running_o, done_o, pass_o, fail_o, timeout_o, stall_o;
   logic [31:0] exit_code_o, cycle_count_o;

   riscv_sim_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .pc_i          (pc_i),
      .memory_write_i(memory_write_i),
      .alu_result_i  (alu_result_i),
      .write_data_i  (write_data_i),
      .core_rst_o    (core_rst_o),
      .running_o     (running_o),
      .done_o        (done_o),
      .pass_o        (pass_o),
      .fail_o        (fail_o),
      .timeout_o     (timeout_o),
      .stall_o       (stall_o),
      .exit_code_o   (exit_code_o),
      .cycle_count_o (cycle_count_o)
   );

   always #5 clk = ~clk;

   // Run schedule. Times are posedge numbers; k is the RUN cycle index (0 = first RUN cycle).
   typedef struct {
      bit          valid;
      int          s;        // edge that samples the start pulse
      int          r;        // edge that samples a reset pulse, -1 none
      int          h;        // pc frozen from run cycle h, -1 never
      logic [31:0] v;        // frozen pc value
      int          st;       // run cycle of the single store, -1 none
      logic [31:0] st_addr;
      logic [31:0] st_data;
      bit          extra;    // extra start pulses in HOLD and RUN
      int          e;        // run cycle in which the run ends
      int          kind;     // 1 pass 2 fail 3 stall 4 timeout
      logic [31:0] code;
   } cfg_t;

   typedef struct {
      logic        core_rst, running, done, pass, fail, timeout, stall;
      logic [31:0] code, count;
   } outs_t;

   cfg_t  cfg;
   outs_t rest;
   int    edge_n = 0;
   bit    init_rst = 1'b1;
   int    checks = 0;
   int    errors = 0;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30) $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pc_at(input cfg_t c, input int k);
      if (k < 0) return 32'h0;
      if (c.h >= 0 && k >= c.h) return c.v;
      return 32'(4 * k);
   endfunction

   // Walk the run cycle by cycle applying the exit rules in priority order.
   function automatic cfg_t with_exit(input cfg_t c);
      logic [31:0] prev = '0;
      logic [31:0] pc;
      int          eq = 0;
      for (int k = 0; k < MaxCyc; k++) begin
         pc = pc_at(c, k);
         eq = (k > 0 && pc == prev) ? eq + 1 : 0;
         c.e = k;
         if (k == c.st && c.st_addr == ToHost) begin
            c.kind = (c.st_data == 32'd1) ? 1 : 2;
            c.code = c.st_data >> 1;
            return c;
         end
         if (eq >= StallLen) begin
            c.kind = 3; c.code = '0;
            return c;
         end
         if (k == MaxCyc - 1) begin
            c.kind = 4; c.code = '0;
            return c;
         end
         prev = pc;
      end
      return c;
   endfunction

   function automatic outs_t zero_outs();
      outs_t o;
      o.core_rst = 0; o.running = 0; o.done = 0; o.pass = 0; o.fail = 0;
      o.timeout = 0; o.stall = 0; o.code = '0; o.count = '0;
      return o;
   endfunction

   function automatic outs_t done_of(input cfg_t c);
      outs_t o = zero_outs();
      o.done = 1; o.pass = (c.kind == 1); o.fail = (c.kind == 2);
      o.stall = (c.kind == 3); o.timeout = (c.kind == 4);
      o.code = c.code; o.count = 32'(c.e + 1);
      return o;
   endfunction

   function automatic outs_t expect_at(input int e);
      outs_t o = zero_outs();
      int    d;
      if (!cfg.valid || e < cfg.s) return rest;
      if (cfg.r >= 0 && e >= cfg.r) return o;
      d = e - cfg.s;
      if (d < HoldLen) return o;
      if (d <= HoldLen + cfg.e) begin
         o.core_rst = 1; o.running = 1; o.count = 32'(d - HoldLen);
         return o;
      end
      return done_of(cfg);
   endfunction

   always @(negedge clk) begin
      outs_t x;
      if (edge_n >= 1) begin
         x = expect_at(edge_n);
         check($sformatf("e%0d core_rst_o", edge_n), {31'b0, core_rst_o}, {31'b0, x.core_rst});
         check($sformatf("e%0d running_o", edge_n), {31'b0, running_o}, {31'b0, x.running});
         check($sformatf("e%0d done_o", edge_n), {31'b0, done_o}, {31'b0, x.done});
         check($sformatf("e%0d pass_o", edge_n), {31'b0, pass_o}, {31'b0, x.pass});
         check($sformatf("e%0d fail_o", edge_n), {31'b0, fail_o}, {31'b0, x.fail});
         check($sformatf("e%0d timeout_o", edge_n), {31'b0, timeout_o}, {31'b0, x.timeout});
         check($sformatf("e%0d stall_o", edge_n), {31'b0, stall_o}, {31'b0, x.stall});
         check($sformatf("e%0d exit_code_o", edge_n), exit_code_o, x.code);
         check($sformatf("e%0d cycle_count_o", edge_n), cycle_count_o, x.count);
      end
   end

   task automatic drive();
      int k = cfg.valid ? edge_n - cfg.s - HoldLen : -100;
      rst_i = !(init_rst || (cfg.valid && cfg.r >= 0 && edge_n == cfg.r - 1));
      start_i = cfg.valid && (edge_n == cfg.s - 1 || (cfg.extra && (k == -2 || k == 5)));
      pc_i = pc_at(cfg, k);
      memory_write_i = cfg.valid && (k == cfg.st);
      alu_result_i = cfg.st_addr;
      write_data_i = cfg.st_data;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive();
   endtask

   function automatic cfg_t mk(input int h, input logic [31:0] v, input int st,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int r, input bit extra);
      cfg_t c;
      c.valid = 0; c.s = 0; c.r = r; c.h = h; c.v = v; c.st = st; c.st_addr = addr;
      c.st_data = data; c.extra = extra; c.e = 0; c.kind = 0; c.code = '0;
      return with_exit(c);
   endfunction

   task automatic run(input cfg_t c);
      int stop;
      if (cfg.valid) rest = (cfg.r >= 0) ? zero_outs() : done_of(cfg);
      c.s = edge_n + 3;
      c.valid = 1;
      cfg = c;
      stop = (c.r >= 0) ? c.r + 3 : c.s + HoldLen + c.e + 4;
      while (edge_n < stop) step();
   endtask

   initial begin
      cfg_t c;
      cfg.valid = 0; cfg.r = -1; cfg.st = -1; cfg.h = -1;
      rest = zero_outs();
      repeat (3) step();
      init_rst = 0;
      repeat (3) step();

      // Pass: store 1 at run cycle 20, with stray start pulses in HOLD and RUN
      c = mk(-1, 0, 20, ToHost, 32'd1, -1, 1);
      check("pass_exit_cycle", 32'(c.e), 32'd20);
      check("pass_kind", 32'(c.kind), 32'd1);
      check("pass_count", done_of(c).count, 32'd21);
      run(c);

      // Fail, started straight from DONE
      c = mk(-1, 0, 12, ToHost, 32'd7, -1, 0);
      check("fail_kind", 32'(c.kind), 32'd2);
      check("fail_code", c.code, 32'd3);
      run(c);

      // Stall: pc frozen at 0x40 from run cycle 10, non-mailbox store ignored
      c = mk(10, 32'h40, 14, 32'h0000_1004, 32'd1, -1, 0);
      check("stall_exit_cycle", 32'(c.e), 32'd18);
      check("stall_kind", 32'(c.kind), 32'd3);
      run(c);

      // Reset during run cycle 15, then a fresh run
      c = mk(-1, 0, -1, ToHost, 32'd0, 0, 0);
      c.r = edge_n + 3 + HoldLen + 16;
      run(c);
      c = mk(-1, 0, 5, ToHost, 32'd1, -1, 0);
      check("restart_count", done_of(c).count, 32'd6);
      run(c);

      // Timeout
      c = mk(-1, 0, -1, ToHost, 32'd0, -1, 0);
      check("timeout_kind", 32'(c.kind), 32'd4);
      check("timeout_count", done_of(c).count, 32'd1000);
      run(c);

      // Mailbox in the timeout cycle wins
      c = mk(-1, 0, MaxCyc - 1, ToHost, 32'd1, -1, 0);
      check("tie_kind", 32'(c.kind), 32'd1);
      check("tie_count", done_of(c).count, 32'd1000);
      run(c);

      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_sim_ctrl.md
RISCV_SIM_CTRL -- requirements
Module: riscv_sim_ctrl

Interface
REQ-001 The block SHALL have parameter RegBits, default 32, meaning the core data/address width.
REQ-002 The block SHALL have parameter CntBits, default 32, meaning the cycle counter width.
REQ-003 The block SHALL have parameter ResetCycles, default 4, meaning the number of cycles core reset is held (1..255).
REQ-004 The block SHALL have parameter MaxCycles, default 1000, meaning the run-cycle timeout limit.
REQ-005 The block SHALL have parameter StallCycles, default 8, meaning consecutive unchanged-PC cycles that count as a halt (>=2).
REQ-006 The block SHALL have parameter ToHostAddr, default 32'h0000_1000, meaning the exit-mailbox store address.
REQ-007 Ports SHALL be:
 clk_i  in  1  single clock, all logic on rising edge
 rst_i  in  1  synchronous, active-low reset
 start_i  in  1  begin a run (sampled in IDLE/DONE)
 pc_i  in  RegBits  core program counter
 memory_write_i  in  1  core data-memory write enable
 alu_result_i  in  RegBits  core store address
 write_data_i  in  RegBits  core store data
 core_rst_o  out  1  active-low reset to core
 running_o  out  1  high in RUN
 done_o  out  1  high in DONE
 pass_o  out  1  exit via mailbox, data == 1
 fail_o  out  1  exit via mailbox, data != 1
 timeout_o  out  1  exit via MaxCycles
 stall_o  out  1  exit via stuck PC
 exit_code_o  out  RegBits  mailbox data >> 1 (zero-filled MSB)
 cycle_count_o  out  CntBits  cycles spent in RUN

Function
REQ-008 The FSM SHALL have states IDLE, HOLD, RUN, DONE.
REQ-009 IDLE: core_rst_o=0; start_i=1 -> HOLD next cycle, hold counter cleared, cycle_count_o cleared, all exit flags cleared.
REQ-010 HOLD: core_rst_o=0 for exactly ResetCycles cycles, then -> RUN; core_rst_o=1 from the first RUN cycle.
REQ-011 RUN: cycle_count_o SHALL increment by 1 each RUN cycle, saturating at all-ones (no wrap).
REQ-012 Mailbox hit = memory_write_i && alu_result_i == ToHostAddr, evaluated only in RUN.
REQ-013 On mailbox hit: write_data_i == 1 -> pass_o=1; else fail_o=1 and exit_code_o = write_data_i >> 1; -> DONE next cycle.
REQ-014 Stall detect: a counter SHALL increment each RUN cycle pc_i equals the previous cycle's pc_i, reset to 0 on change; reaching StallCycles-1 -> stall_o=1, -> DONE.
REQ-015 The first RUN cycle SHALL capture pc_i as reference without counting a stall.
REQ-016 Timeout: cycle_count_o reaching MaxCycles-1 while in RUN with no other exit -> timeout_o=1, -> DONE.
REQ-017 Simultaneous exit events SHALL be resolved with priority mailbox > stall > timeout; exactly one exit flag set per run.
REQ-018 DONE: core_rst_o=0 (core frozen), done_o=1, flags, exit_code_o, cycle_count_o held stable; start_i=1 -> HOLD (new run, flags cleared).
REQ-019 start_i SHALL be ignored in HOLD and RUN.
REQ-020 Outputs SHALL be registered; running_o/done_o decode from state register.

Reset
REQ-021 When rst_i=0 at a rising edge: state=IDLE, core_rst_o=0, running_o=0, done_o=0, all exit flags 0, exit_code_o=0, cycle_count_o=0, internal counters 0.
REQ-022 Reset asserted in any state, including mid-HOLD or mid-RUN, SHALL take effect at the next edge with no completion of the run.

Verification
REQ-023 Pass: start_i pulse, pc_i increments by 4, store 1 to 0x1000 at RUN cycle 20 -> core_rst_o low 4 cycles, pass_o=1, done_o=1, cycle_count_o=21, exit_code_o=0.
REQ-024 Fail: store 7 to 0x1000 -> fail_o=1, exit_code_o=3, pass_o=0.
REQ-025 Stall: pc_i held at 0x40 from RUN cycle 10 -> stall_o=1 after 8 equal-PC cycles; store to 0x1004 ignored.
REQ-026 Timeout: pc_i incrementing, no mailbox store -> timeout_o=1, cycle_count_o=1000; same-cycle mailbox store at limit -> pass_o wins, timeout_o=0.
REQ-027 Reset mid-RUN at cycle 15 -> all outputs reset values next edge; restart via start_i -> fresh run with cycle_count_o from 0.
REQ-028 Re-run from DONE: start_i in DONE -> flags cleared, HOLD 4 cycles, second run reports independently.
